core_mem_timed: RTL and testbench
=================================

// Module: core_mem_timed
// PURPOSE
//  Parametrised core-memory emulator: timed read/restore cycle mimicking PDP-8 core timing.
//  Sits between CPU major-state logic and block RAM; replaces fixed 32Kx12 store.
//  Adds latched address, restore-vs-write select, busy/overlap flags, optional parity.
// PARAMETERS
//  AW        15   address width (depth = 2**AW words)
//  DW        12   data width
//  TW        8    timer width
//  READ_AT   30   timer value at which the word is read into data_out
//  STB_START 50   first timer value with strobe asserted
//  STB_END   60   first timer value with strobe deasserted
//  WRITE_AT  80   timer value of the single write-back cycle
//  DONE_AT   149  timer value from which mem_done_n is low
//  T_MAX     160  timer stops counting at this value
// PORTS
//  clk         in   1   system clock (100 MHz)
//  rst_n       in   1   asynchronous active-low reset
//  mem_start   in   1   cycle request; rising edge starts a cycle
//  write_mb    in   1   1: write data_in at WRITE_AT; 0: restore read word
//  addr        in   AW  word address, latched on start edge
//  data_in     in   DW  write data, sampled at WRITE_AT
//  data_out    out  DW  read word, registered
//  strobe_n    out  1   active-low sense strobe
//  mem_done_n  out  1   active-low cycle complete
//  busy        out  1   cycle in progress (timer 1..DONE_AT-1)
//  overlap     out  1   sticky: start edge seen while busy; cleared by next accepted start
//  parity_err  out  1   (MEM_PARITY_EN only) read word failed odd parity
// BEHAVIOUR
//  Reset (async, rst_n low): timer=0, data_out=0, strobe_n=1, mem_done_n=1, busy=0,
//   overlap=0, parity_err=0, start-edge register=0. RAM contents not reset.
//  Start edge: mem_start=1 and prev=0. If not busy: addr_q<=addr, timer<=1, overlap<=0.
//   If busy: ignored for timing, overlap<=1. Start edge during done (timer>=DONE_AT) accepted.
//  Timer: increments while 0<timer<T_MAX; holds at T_MAX; 0 = idle after reset.
//  At timer==READ_AT: data_out<=ram[addr_q]; rd_q<=same word (restore buffer).
//  strobe_n low for STB_START<=timer<STB_END (exactly STB_END-STB_START cycles).
//  At timer==WRITE_AT: ram[addr_q]<=write_mb ? data_in : rd_q. Exactly one write per cycle.
//  mem_done_n low for timer>=DONE_AT; stays low until next accepted start or reset.
//  busy = (timer!=0) && (timer<DONE_AT).
//  Addr changes after start edge have no effect on the cycle in progress.
//  Reset mid-cycle: if before WRITE_AT no write occurs (word left unchanged; no destructive
//   read modelled). All flags return to reset values.
//  Elaboration check: READ_AT<STB_START<STB_END<=WRITE_AT<DONE_AT<=T_MAX<2**TW; else $error.
// CONFIGURATION
//  MEM_PARITY_EN defined: RAM word is DW+1 bits; bit DW stores odd parity of the written data
//   (write_mb path: computed from data_in; restore path: stored bit of rd_q).
//   At READ_AT parity_err<=(^word)==0 (even total = error); held until next READ_AT or reset.
//  MEM_PARITY_EN undefined: RAM is DW bits; parity_err port absent; no parity logic.
// STRUCTURE
//  core_mem_pkg: default timing localparams (READ_AT..T_MAX), odd_parity function.
//  Sub-module core_mem_timer: edge detect, timer, busy/overlap, decoded phase pulses
//   (rd_pulse, wr_pulse, strobe, done). Top holds RAM, addr_q, rd_q, data_out, parity.
// TESTING (defaults, AW=15, DW=12)
//  Write 12'o5252 to 15'o07754 (write_mb=1), then read cycle write_mb=0 -> data_out=12'o5252
//   at READ_AT+1; word still 12'o5252 after restore.
//  Single cycle: strobe_n low exactly 10 clocks (timer 50..59); mem_done_n falls 148 clocks
//   after start edge, stays low through timer hold at 160.
//  Change addr 15'o00000->15'o00001 at timer 10 -> read/write use 15'o00000; 15'o00001 unchanged.
//  Second start edge at timer 40 -> ignored, overlap=1; next edge after done -> overlap=0.
//  rst_n low at timer 60 of write 12'o7777 -> no write, strobe_n=1, mem_done_n=1 immediately.
//  MEM_PARITY_EN: force stored parity bit flipped at addr 15'o00100 -> read sets parity_err=1.

Source files
------------

// File: rtl/core_mem_pkg.sv
// Shared timing defaults and parity helper for the timed core-memory emulator.
package core_mem_pkg;

  localparam int unsigned P_READ_AT   = 30;
  localparam int unsigned P_STB_START = 50;
  localparam int unsigned P_STB_END   = 60;
  localparam int unsigned P_WRITE_AT  = 80;
  localparam int unsigned P_DONE_AT   = 149;
  localparam int unsigned P_T_MAX     = 160;

  // Bit that makes the total number of ones in {bit, d} odd.
  function automatic logic odd_parity(input logic [31:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/core_mem_timer.sv
// Start-edge detection, cycle timer, busy/overlap flags and decoded phase signals
// for the timed core-memory emulator.
module core_mem_timer #(
  parameter int unsigned TW        = 8,
  parameter int unsigned READ_AT   = core_mem_pkg::P_READ_AT,
  parameter int unsigned STB_START = core_mem_pkg::P_STB_START,
  parameter int unsigned STB_END   = core_mem_pkg::P_STB_END,
  parameter int unsigned WRITE_AT  = core_mem_pkg::P_WRITE_AT,
  parameter int unsigned DONE_AT   = core_mem_pkg::P_DONE_AT,
  parameter int unsigned T_MAX     = core_mem_pkg::P_T_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_start,
  output logic start_acc,
  output logic rd_pulse,
  output logic wr_pulse,
  output logic strobe,
  output logic done,
  output logic busy,
  output logic overlap
);

  localparam logic [TW-1:0] READ_T  = TW'(READ_AT);
  localparam logic [TW-1:0] STBS_T  = TW'(STB_START);
  localparam logic [TW-1:0] STBE_T  = TW'(STB_END);
  localparam logic [TW-1:0] WRITE_T = TW'(WRITE_AT);
  localparam logic [TW-1:0] DONE_T  = TW'(DONE_AT);
  localparam logic [TW-1:0] TMAX_T  = TW'(T_MAX);

  logic          start_q, start_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          overlap_q, overlap_d;
  logic          start_edge;

  assign busy       = (timer_q != '0) && (timer_q < DONE_T);
  assign start_edge = mem_start && !start_q;
  assign start_acc  = start_edge && !busy;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    start_d   = mem_start;
    timer_d   = timer_q;
    overlap_d = overlap_q;
    if (start_acc) begin
      timer_d   = TW'(1);
      overlap_d = 1'b0;
    end else begin
      if (start_edge) overlap_d = 1'b1;
      if ((timer_q != '0) && (timer_q < TMAX_T)) timer_d = timer_q + TW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= 1'b0;
      timer_q   <= '0;
      overlap_q <= 1'b0;
    end else begin
      start_q   <= start_d;
      timer_q   <= timer_d;
      overlap_q <= overlap_d;
    end
  end

  assign overlap  = overlap_q;
  assign rd_pulse = (timer_q == READ_T);
  assign wr_pulse = (timer_q == WRITE_T);
  assign strobe   = (timer_q >= STBS_T) && (timer_q < STBE_T);
  assign done     = (timer_q >= DONE_T);

endmodule

// File: rtl/core_mem_timed.sv
// Timed core-memory emulator: PDP-8 style read/restore cycle around a block RAM.
// Optional odd-parity storage and checking enabled by defining MEM_PARITY_EN.
module core_mem_timed
  import core_mem_pkg::*;
#(
  parameter int unsigned AW        = 15,
  parameter int unsigned DW        = 12,
  parameter int unsigned TW        = 8,
  parameter int unsigned READ_AT   = P_READ_AT,
  parameter int unsigned STB_START = P_STB_START,
  parameter int unsigned STB_END   = P_STB_END,
  parameter int unsigned WRITE_AT  = P_WRITE_AT,
  parameter int unsigned DONE_AT   = P_DONE_AT,
  parameter int unsigned T_MAX     = P_T_MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_start,
  input  logic          write_mb,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          strobe_n,
  output logic          mem_done_n,
  output logic          busy,
  output logic          overlap
`ifdef MEM_PARITY_EN
  ,output logic         parity_err
`endif
);

  if (!((READ_AT < STB_START) && (STB_START < STB_END) && (STB_END <= WRITE_AT) &&
        (WRITE_AT < DONE_AT) && (DONE_AT <= T_MAX) && (T_MAX < (32'd1 << TW)))) begin : g_bad_timing
    $error("core_mem_timed: timing parameters out of order or exceed timer width");
  end

`ifdef MEM_PARITY_EN
  localparam int unsigned MW = DW + 1;
`else
  localparam int unsigned MW = DW;
`endif

  logic start_acc, rd_pulse, wr_pulse, strobe, done;

  core_mem_timer #(
    .TW(TW), .READ_AT(READ_AT), .STB_START(STB_START), .STB_END(STB_END),
    .WRITE_AT(WRITE_AT), .DONE_AT(DONE_AT), .T_MAX(T_MAX)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_start (mem_start),
    .start_acc (start_acc),
    .rd_pulse  (rd_pulse),
    .wr_pulse  (wr_pulse),
    .strobe    (strobe),
    .done      (done),
    .busy      (busy),
    .overlap   (overlap)
  );

  logic [MW-1:0] mem [2**AW];
  logic [AW-1:0] addr_q, addr_d;
  logic [MW-1:0] rd_q, rd_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic [MW-1:0] rd_word, wr_word;

  assign rd_word = mem[addr_q];

`ifdef MEM_PARITY_EN
  logic parity_err_q, parity_err_d;
  // Restores copy the stored parity bit untouched so a corrupted word stays detectable.
  assign wr_word = write_mb ? {odd_parity(32'(data_in)), data_in} : rd_q;
`else
  assign wr_word = write_mb ? data_in : rd_q;
`endif

  always_comb begin
    addr_d     = addr_q;
    rd_d       = rd_q;
    data_out_d = data_out_q;
`ifdef MEM_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (start_acc) addr_d = addr;
    if (rd_pulse) begin
      rd_d       = rd_word;
      data_out_d = rd_word[DW-1:0];
`ifdef MEM_PARITY_EN
      parity_err_d = ((^rd_word) == 1'b0);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rd_q       <= '0;
      data_out_q <= '0;
`ifdef MEM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      data_out_q <= data_out_d;
`ifdef MEM_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_pulse) mem[addr_q] <= wr_word;
  end

  assign data_out   = data_out_q;
  assign strobe_n   = !strobe;
  assign mem_done_n = !done;
`ifdef MEM_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_core_mem_timed.sv
// Self-checking bench for core_mem_timed: table-driven full cycles plus directed
// sequences for strobe/done timing, address latching, overlap, mid-cycle reset and parity.
module tb_core_mem_timed;

  localparam int AW = 15;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_start;
  logic          write_mb;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          strobe_n;
  logic          mem_done_n;
  logic          busy;
  logic          overlap;
`ifdef MEM_PARITY_EN
  logic          parity_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int tcnt     = 0;

  core_mem_timed dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_start  (mem_start),
    .write_mb   (write_mb),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .strobe_n   (strobe_n),
    .mem_done_n (mem_done_n),
    .busy       (busy),
    .overlap    (overlap)
`ifdef MEM_PARITY_EN
    ,.parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wmb;
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0o expected %0o (timer %0d)", name, act, exp, tcnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcnt++;
  endtask

  task automatic advance_to(input int t);
    while (tcnt < t) tick();
  endtask

  task automatic start_cycle(input logic [AW-1:0] a, input logic wmb, input logic [DW-1:0] d);
    addr      = a;
    write_mb  = wmb;
    data_in   = d;
    mem_start = 1'b1;
    @(posedge clk);
    #1;
    mem_start = 1'b0;
    tcnt      = 1;
  endtask

  task automatic run_read(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    start_cycle(a, 1'b0, '0);
    advance_to(31);
    check(name, 32'(data_out), 32'(exp));
    advance_to(150);
  endtask

  vec_t vecs[11];

  initial begin
    int first_low, low_count, first_done;

    vecs[0]  = '{15'o07754, 1'b1, 12'o5252, 12'o0000};
    vecs[1]  = '{15'o07754, 1'b0, 12'o0000, 12'o5252};
    vecs[2]  = '{15'o07754, 1'b0, 12'o0000, 12'o5252};
    vecs[3]  = '{15'o00000, 1'b1, 12'o1234, 12'o0000};
    vecs[4]  = '{15'o00001, 1'b1, 12'o4321, 12'o0000};
    vecs[5]  = '{15'o00000, 1'b0, 12'o0000, 12'o1234};
    vecs[6]  = '{15'o00001, 1'b0, 12'o0000, 12'o4321};
    vecs[7]  = '{15'o77777, 1'b1, 12'o0000, 12'o0000};
    vecs[8]  = '{15'o77777, 1'b0, 12'o0000, 12'o0000};
    vecs[9]  = '{15'o77777, 1'b1, 12'o7777, 12'o0000};
    vecs[10] = '{15'o77777, 1'b0, 12'o0000, 12'o7777};

    rst_n     = 1'b0;
    mem_start = 1'b0;
    write_mb  = 1'b0;
    addr      = '0;
    data_in   = '0;
    tick();
    tick();
    check("reset data_out",   32'(data_out),   0);
    check("reset strobe_n",   32'(strobe_n),   1);
    check("reset mem_done_n", 32'(mem_done_n), 1);
    check("reset busy",       32'(busy),       0);
    check("reset overlap",    32'(overlap),    0);
    rst_n = 1'b1;
    tick();
    check("idle busy", 32'(busy), 0);

    for (int i = 0; i < 11; i++) begin
      start_cycle(vecs[i].addr, vecs[i].wmb, vecs[i].din);
      check($sformatf("vec%0d busy at start", i), 32'(busy), 1);
      check($sformatf("vec%0d done_n at start", i), 32'(mem_done_n), 1);
      advance_to(31);
      if (!vecs[i].wmb)
        check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp));
      advance_to(150);
      check($sformatf("vec%0d done_n", i), 32'(mem_done_n), 0);
      check($sformatf("vec%0d busy at end", i), 32'(busy), 0);
    end

    // Strobe window and done timing, sampled once per timer value
    start_cycle(15'o07754, 1'b0, '0);
    first_low = -1; low_count = 0; first_done = -1;
    while (tcnt <= 170) begin
      if (!strobe_n) begin
        low_count++;
        if (first_low < 0) first_low = tcnt;
      end
      if (!mem_done_n && first_done < 0) first_done = tcnt;
      tick();
    end
    check("strobe low count", 32'(low_count), 10);
    check("strobe first low timer", 32'(first_low), 50);
    check("done first low timer", 32'(first_done), 149);
    check("done held at timer max", 32'(mem_done_n), 0);
    check("restore keeps word", 32'(data_out), 12'o5252);

    // Address changes after the start edge are ignored
    start_cycle(15'o00000, 1'b1, 12'o3333);
    advance_to(10);
    addr = 15'o00001;
    advance_to(150);
    run_read("latched addr written", 15'o00000, 12'o3333);
    run_read("other addr untouched", 15'o00001, 12'o4321);

    // Second start edge mid-cycle sets overlap and does not restart the timer
    start_cycle(15'o00000, 1'b0, '0);
    advance_to(40);
    mem_start = 1'b1;
    tick();
    mem_start = 1'b0;
    check("overlap set", 32'(overlap), 1);
    check("busy during overlap", 32'(busy), 1);
    advance_to(150);
    check("overlap timer not restarted", 32'(mem_done_n), 0);
    check("overlap sticky", 32'(overlap), 1);
    start_cycle(15'o00000, 1'b0, '0);
    check("overlap cleared by accepted start", 32'(overlap), 0);
    advance_to(150);

    // Reset inside the strobe window, before the write-back
    start_cycle(15'o00000, 1'b1, 12'o7777);
    advance_to(55);
    check("strobe low before reset", 32'(strobe_n), 0);
    rst_n = 1'b0;
    #1;
    check("midreset strobe_n", 32'(strobe_n),   1);
    check("midreset done_n",   32'(mem_done_n), 1);
    check("midreset busy",     32'(busy),       0);
    check("midreset data_out", 32'(data_out),   0);
    tick();
    rst_n = 1'b1;
    tick();
    run_read("no write after reset", 15'o00000, 12'o3333);

`ifdef MEM_PARITY_EN
    start_cycle(15'o00100, 1'b1, 12'o5252);
    advance_to(150);
    run_read("parity word read", 15'o00100, 12'o5252);
    check("parity ok", 32'(parity_err), 0);
    dut.mem[15'o00100][DW] = ~dut.mem[15'o00100][DW];
    run_read("parity bad word read", 15'o00100, 12'o5252);
    check("parity error flagged", 32'(parity_err), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
